// File: rtl/keypad_matrix_emulator_if.sv
// Key-entry port of the keypad matrix emulator.
// A sequencer (master) offers a 5-bit key code with key_valid; the emulator
// (slave) answers with key_ready. A transfer happens on a clock edge where
// key_valid and key_ready are both high.
//   key_code   master->slave  5  key to press (0..15 legal, 16..31 illegal)
//   key_valid  master->slave  1  key_code is valid
//   key_ready  slave->master  1  emulator queue can take a key
interface keypad_matrix_emulator_if;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad emulator.
// Queued key codes are replayed as physical keystrokes towards a column-scanning
// driver: while a key is pressed, the row line of that key follows the strobe of
// its column; press and release lengths are counted in full column sweeps.
// Ports:
//   clk          system clock (shared with the scan driver)
//   rst_n        asynchronous active-low reset
//   key_if       key-entry valid/ready port (slave side)
//   col          one-hot column strobe from the scan driver
//   fila         one-hot row response, 0 when no key is seen
//   pressed      high while a key is held down
//   key_done     one-cycle pulse when a key is released
//   err_invalid  one-cycle pulse after an illegal code was consumed
//   busy         a key is being played or waiting in the queue
module keypad_matrix_emulator #(
    parameter int HOLD_SCANS = 4,
    parameter int GAP_SCANS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    keypad_matrix_emulator_if.slave  key_if,
    input  logic [3:0]               col,
    output logic [3:0]               fila,
    output logic                     pressed,
    output logic                     key_done,
    output logic                     err_invalid,
    output logic                     busy
);
    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [7:0] HOLD_C = 8'(HOLD_SCANS);
    localparam logic [7:0] GAP_C  = 8'(GAP_SCANS);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          done_nxt;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    key_col, key_row;
    logic [7:0]    head_map;
    logic          accept, push, pop, sweep;

    // Column/row one-hot pair of a key code, packed as {col, row}.
    function automatic logic [7:0] key_map(input logic [3:0] code);
        case (code)
            4'h1: key_map = {4'b0001, 4'b0001};
            4'h4: key_map = {4'b0001, 4'b0010};
            4'h7: key_map = {4'b0001, 4'b0100};
            4'hF: key_map = {4'b0001, 4'b1000};
            4'h2: key_map = {4'b0010, 4'b0001};
            4'h5: key_map = {4'b0010, 4'b0010};
            4'h8: key_map = {4'b0010, 4'b0100};
            4'h0: key_map = {4'b0010, 4'b1000};
            4'h3: key_map = {4'b0100, 4'b0001};
            4'h6: key_map = {4'b0100, 4'b0010};
            4'h9: key_map = {4'b0100, 4'b0100};
            4'hE: key_map = {4'b0100, 4'b1000};
            4'hA: key_map = {4'b1000, 4'b0001};
            4'hB: key_map = {4'b1000, 4'b0010};
            4'hC: key_map = {4'b1000, 4'b0100};
            4'hD: key_map = {4'b1000, 4'b1000};
            default: key_map = 8'h00;
        endcase
    endfunction

    // Depth is a power of two, so the count MSB alone flags "full".
    assign key_if.key_ready = ~count[AW];
    assign accept   = key_if.key_valid & key_if.key_ready;
    // Illegal codes are still consumed by the handshake, just never queued.
    assign push     = accept & ~key_if.key_code[4];
    // Pop looks at the registered count only: no same-cycle push bypass.
    assign pop      = (state == IDLE) && (count != '0);
    assign sweep    = (col == 4'b1000);
    assign head_map = key_map(mem[rd_ptr]);

    assign pressed  = (state == PRESS);
    assign busy     = (state != IDLE) || (count != '0);
    // Exact compare: non-one-hot strobes never light a row.
    assign fila     = (pressed && col == key_col) ? key_row : 4'b0000;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = PRESS;
                    cnt_nxt   = 8'd0;
                end
            end
            PRESS: begin
                if (sweep) begin
                    if (cnt + 8'd1 == HOLD_C) begin
                        state_nxt = GAP;
                        cnt_nxt   = 8'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                if (sweep) begin
                    if (cnt + 8'd1 == GAP_C) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            key_done    <= 1'b0;
            err_invalid <= 1'b0;
            key_col     <= 4'b0000;
            key_row     <= 4'b0000;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_done    <= done_nxt;
            err_invalid <= accept & key_if.key_code[4];
            if (pop) begin
                key_col <= head_map[7:4];
                key_row <= head_map[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_if.key_code[3:0];
    end
endmodule
